// File: rtl/seg7_scan_decoder_if.sv
// Scan-bus bundle for seg7_scan_decoder: the multiplexed segment/anode inputs
// plus the reconstructed frame outputs.
interface seg7_scan_decoder_if;
    logic [7:0]  atog;           // active-low segments, [7:1]=a..g, [0]=dp
    logic [3:0]  an;             // active-low digit enables
    logic [15:0] digits;         // nibble i = digit i
    logic [3:0]  dp;             // decimal point per digit, 1 = lit
    logic [3:0]  blank;          // digit had no segments lit
    logic        frame_err;      // some digit in the frame was undecodable
    logic        frame_valid;    // one-cycle pulse on publish
    logic        frame_changed;  // publish pulse when the frame differs

    // Display scanner side: drives the bus, observes the decoded frame.
    modport master (
        output atog, an,
        input  digits, dp, blank, frame_err, frame_valid, frame_changed
    );

    // Decoder side.
    modport slave (
        input  atog, an,
        output digits, dp, blank, frame_err, frame_valid, frame_changed
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Receives a time-multiplexed 7-segment scan, waits for each digit strobe to
// settle, decodes it to a hex nibble and publishes complete 4-digit frames.
// rst_n is expected to be released synchronously by the reset controller.
module seg7_scan_decoder #(
    parameter int unsigned SETTLE = 4   // 2..255
) (
    input logic                clk,
    input logic                rst_n,
    seg7_scan_decoder_if.slave bus
);

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    typedef struct packed {
        logic [3:0] nib;
        logic       blank;
        logic       err;
    } dec_t;

    // Lit-segment set, bit 6 = a ... bit 0 = g.
    function automatic dec_t decode(input logic [6:0] lit);
        dec_t d;
        d = '{nib: 4'h0, blank: 1'b0, err: 1'b0};
        case (lit)
            7'h7E: d.nib = 4'h0;
            7'h30: d.nib = 4'h1;
            7'h6D: d.nib = 4'h2;
            7'h79: d.nib = 4'h3;
            7'h33: d.nib = 4'h4;
            7'h5B: d.nib = 4'h5;
            7'h5F: d.nib = 4'h6;
            7'h70: d.nib = 4'h7;
            7'h7F: d.nib = 4'h8;
            7'h7B: d.nib = 4'h9;
            7'h77: d.nib = 4'hA;
            7'h1F: d.nib = 4'hB;
            7'h4E: d.nib = 4'hC;
            7'h3D: d.nib = 4'hD;
            7'h4F: d.nib = 4'hE;
            7'h47: d.nib = 4'hF;
            7'h00: d.blank = 1'b1;
            default: d.err = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic one_hot_low(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
    endfunction

    function automatic logic [1:0] digit_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    logic [7:0]  atog_q;
    logic [3:0]  an_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        strobe;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] sh_nib_q, sh_nib_d;
    logic [3:0]  sh_dp_q, sh_dp_d;
    logic [3:0]  sh_blank_q, sh_blank_d;
    logic [3:0]  sh_err_q, sh_err_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  dp_q, dp_d;
    logic [3:0]  blank_q, blank_d;
    logic        err_q, err_d;
    logic        valid_q, valid_d;
    logic        changed_q, changed_d;
    dec_t        dec;
    logic [1:0]  idx;

    // Input stage: everything downstream sees only the registered bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            atog_q <= 8'hFF;
            an_q   <= 4'hF;
        end else begin
            // NOTE: non-blocking assignment for every flop so all state updates
            // see the same pre-edge values regardless of block ordering.
            atog_q <= bus.atog;
            an_q   <= bus.an;
        end
    end

    // Settle counter: counts registered cycles the current one-hot an_q has held;
    // the strobe marks the single SETTLE-1 -> SETTLE step of each dwell.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal
        // unassigned, which would infer a latch.
        cnt_d  = cnt_q;
        strobe = 1'b0;
        if (bus.an != an_q) begin
            cnt_d = one_hot_low(bus.an) ? 8'd1 : 8'd0;
        end else if (!one_hot_low(an_q)) begin
            cnt_d = 8'd0;
        end else if (cnt_q != SETTLE_C) begin
            cnt_d  = cnt_q + 8'd1;
            strobe = (cnt_q == SETTLE_C - 8'd1);
        end
    end

    // Sample into the shadow frame and publish when the fourth digit arrives.
    always_comb begin
        dec        = decode(~atog_q[7:1]);
        idx        = digit_index(an_q);
        seen_d     = seen_q;
        sh_nib_d   = sh_nib_q;
        sh_dp_d    = sh_dp_q;
        sh_blank_d = sh_blank_q;
        sh_err_d   = sh_err_q;
        digits_d   = digits_q;
        dp_d       = dp_q;
        blank_d    = blank_q;
        err_d      = err_q;
        valid_d    = 1'b0;
        changed_d  = 1'b0;
        if (strobe) begin
            sh_nib_d[{idx, 2'b00} +: 4] = dec.nib;
            sh_dp_d[idx]    = ~atog_q[0];
            sh_blank_d[idx] = dec.blank;
            sh_err_d[idx]   = dec.err;
            seen_d          = seen_q | (4'b0001 << idx);
            if (seen_d == 4'hF) begin
                digits_d  = sh_nib_d;
                dp_d      = sh_dp_d;
                blank_d   = sh_blank_d;
                err_d     = |sh_err_d;
                valid_d   = 1'b1;
                changed_d = {sh_nib_d, sh_dp_d, sh_blank_d} != {digits_q, dp_q, blank_q};
                seen_d    = 4'h0;
                sh_err_d  = 4'h0;
            end
        end
    end

    // Counter, seen mask and shadow frame registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow frame is reset too, so a reset mid-scan can never
            // leak stale digits into the next published frame.
            cnt_q      <= 8'd0;
            seen_q     <= 4'h0;
            sh_nib_q   <= 16'h0;
            sh_dp_q    <= 4'h0;
            sh_blank_q <= 4'h0;
            sh_err_q   <= 4'h0;
        end else begin
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            sh_nib_q   <= sh_nib_d;
            sh_dp_q    <= sh_dp_d;
            sh_blank_q <= sh_blank_d;
            sh_err_q   <= sh_err_d;
        end
    end

    // Published frame and its status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q  <= 16'h0;
            dp_q      <= 4'h0;
            blank_q   <= 4'hF;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            digits_q  <= digits_d;
            dp_q      <= dp_d;
            blank_q   <= blank_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

    assign bus.digits        = digits_q;
    assign bus.dp            = dp_q;
    assign bus.blank         = blank_q;
    assign bus.frame_err     = err_q;
    assign bus.frame_valid   = valid_q;
    assign bus.frame_changed = changed_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed and randomized scans of seg7_scan_decoder against a frame-level
// model that reasons in digit values and segment-letter strings.
module tb_seg7_scan_decoder;

    localparam int SETTLE   = 4;
    localparam int K_BLANK  = 16;
    localparam int K_BAD    = 17;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seg7_scan_decoder_if bus ();

    seg7_scan_decoder #(.SETTLE(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Segment letters lit for each hex value.
    string seg_names [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                              "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                              "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    // Model of the frame being assembled and of the last published frame.
    int          m_nib   [4];
    bit          m_dp    [4];
    bit          m_blank [4];
    bit          m_err   [4];
    bit          m_seen  [4];
    logic [15:0] p_digits;
    logic [3:0]  p_dp;
    logic [3:0]  p_blank;
    int          last_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] lit_of(input string s);
        logic [6:0] r;
        r = 7'h0;
        for (int i = 0; i < s.len(); i++) r[6 - (int'(s[i]) - 97)] = 1'b1;
        return r;
    endfunction

    function automatic bit in_table(input logic [6:0] lit);
        for (int v = 0; v < 16; v++) if (lit_of(seg_names[v]) == lit) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [6:0] bad_lit();
        logic [6:0] r;
        do r = 7'($urandom); while (r == 7'h0 || in_table(r));
        return r;
    endfunction

    function automatic bit all_seen();
        return m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.an   = 4'hF;
        bus.atog = 8'hFF;
        #2;
        chk("rst_digits", 32'(bus.digits), 32'h0);
        chk("rst_dp", 32'(bus.dp), 32'h0);
        chk("rst_blank", 32'(bus.blank), 32'hF);
        chk("rst_err", 32'(bus.frame_err), 32'h0);
        chk("rst_valid", 32'(bus.frame_valid), 32'h0);
        chk("rst_changed", 32'(bus.frame_changed), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_seen[i] = 1'b0;
            m_err[i]  = 1'b0;
        end
        p_digits = 16'h0;
        p_dp     = 4'h0;
        p_blank  = 4'hF;
        last_idx = -1;
    endtask

    // Hold a non-digit an value; nothing may be published meanwhile.
    task automatic hold_an(input logic [3:0] v, input int n);
        bus.an   = v;
        last_idx = -1;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(bus.frame_valid), 32'h0);
        end
    endtask

    // Show one digit for `dwell` cycles. kind: 0..15 value, K_BLANK, K_BAD.
    task automatic scan_digit(input int idx, input int kind, input bit dpl, input int dwell);
        logic [6:0]  lit;
        bit          pub;
        logic [15:0] e_digits;
        logic [3:0]  e_dp, e_blank;
        bit          e_err, e_changed;
        if (kind < 16)            lit = lit_of(seg_names[kind]);
        else if (kind == K_BLANK) lit = 7'h0;
        else                      lit = bad_lit();
        if (idx == last_idx) begin
            bus.an = 4'hF;
            @(posedge clk);
            #1;
            chk("gap_valid", 32'(bus.frame_valid), 32'h0);
        end
        bus.an   = ~(4'b0001 << idx);
        bus.atog = {~lit, ~dpl};
        last_idx = idx;
        pub      = 1'b0;
        if (dwell >= SETTLE) begin
            m_seen[idx]  = 1'b1;
            m_nib[idx]   = (kind < 16) ? kind : 0;
            m_dp[idx]    = dpl;
            m_blank[idx] = (kind == K_BLANK);
            m_err[idx]   = (kind == K_BAD);
            pub          = all_seen();
        end
        for (int c = 1; c <= dwell; c++) begin
            @(posedge clk);
            #1;
            chk("frame_valid", 32'(bus.frame_valid), 32'(pub && c == SETTLE));
            if (pub && c == SETTLE) begin
                e_err = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    e_digits[i*4 +: 4] = 4'(m_nib[i]);
                    e_dp[i]    = m_dp[i];
                    e_blank[i] = m_blank[i];
                    e_err      = e_err | m_err[i];
                end
                e_changed = ({e_digits, e_dp, e_blank} != {p_digits, p_dp, p_blank});
                chk("digits", 32'(bus.digits), 32'(e_digits));
                chk("dp", 32'(bus.dp), 32'(e_dp));
                chk("blank", 32'(bus.blank), 32'(e_blank));
                chk("frame_err", 32'(bus.frame_err), 32'(e_err));
                chk("frame_changed", 32'(bus.frame_changed), 32'(e_changed));
                p_digits = e_digits;
                p_dp     = e_dp;
                p_blank  = e_blank;
                for (int i = 0; i < 4; i++) begin
                    m_seen[i] = 1'b0;
                    m_err[i]  = 1'b0;
                end
            end else begin
                chk("changed_idle", 32'(bus.frame_changed), 32'h0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int ord [4];
        int tmp, j;
        bus.an   = 4'hF;
        bus.atog = 8'hFF;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Digits 1,2,3,4 in natural order, then the same frame again.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) scan_digit(i, i + 1, 1'b0, 6);
        chk("frame_4321", 32'(p_digits), 32'h4321);

        // Short dwell on digit 2 leaves it unseen until a full dwell.
        scan_digit(0, 5, 1'b0, 6);
        scan_digit(1, 6, 1'b0, 6);
        scan_digit(2, 7, 1'b0, 3);
        scan_digit(3, 8, 1'b0, 6);
        scan_digit(2, 9, 1'b0, 6);

        // Undecodable a+g on digit 1, then a clean frame.
        scan_digit(0, 1, 1'b0, 6);
        bus.an   = ~4'b0010;
        bus.atog = {~lit_of("ag"), 1'b1};
        last_idx = 1;
        m_seen[1] = 1'b1; m_nib[1] = 0; m_dp[1] = 1'b0; m_blank[1] = 1'b0; m_err[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            chk("bad_valid", 32'(bus.frame_valid), 32'h0);
        end
        scan_digit(2, 2, 1'b0, 6);
        scan_digit(3, 3, 1'b0, 6);
        for (int i = 0; i < 4; i++) scan_digit(i, i + 1, 1'b0, 6);

        // Digit 3 dark with its decimal point lit.
        for (int i = 0; i < 3; i++) scan_digit(i, i + 7, 1'b0, 6);
        scan_digit(3, K_BLANK, 1'b1, 6);

        // Two enables low, then all high: no samples may be taken.
        for (int i = 0; i < 3; i++) scan_digit(i, 15 - i, 1'b1, 5);
        hold_an(4'b1100, 10);
        hold_an(4'b1111, 3);
        scan_digit(3, 12, 1'b0, 5);

        // Reset after three digits discards the partial frame.
        for (int i = 0; i < 3; i++) scan_digit(i, i, 1'b0, 6);
        do_reset();
        scan_digit(3, 4, 1'b0, 6);
        // A frame identical to the reset outputs does not report a change.
        for (int i = 0; i < 4; i++) scan_digit(i, K_BLANK, 1'b0, 6);

        // Reverse scan order with A,b,C,d.
        for (int i = 3; i >= 0; i--) scan_digit(i, 10 + i, 1'b0, 6);
        chk("frame_dCbA", 32'(p_digits), 32'hDCBA);

        // Randomized scans: order, content, decimal points and dwell lengths.
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < 4; i++) ord[i] = i;
            for (int i = 3; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
            end
            for (int i = 0; i < 4; i++)
                scan_digit(ord[i], int'($urandom_range(0, 17)), 1'($urandom),
                           int'($urandom_range(2, 8)));
            for (int i = 0; i < 4; i++)
                if (!m_seen[i])
                    scan_digit(i, int'($urandom_range(0, 17)), 1'($urandom),
                               int'($urandom_range(SETTLE, 8)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
